// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets N byte producers share one UART_Tx.
// Each grant moves one byte through a start handshake and waits for the frame to finish.
module uart_tx_arbiter #(
  parameter int N             = 4,
  parameter int START_TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_val,
  input  logic [8*N-1:0] req_data,
  output logic [N-1:0]   req_ack,
  input  logic           busy,
  output logic           tx_val,
  output logic [7:0]     tx_data,
  output logic [N-1:0]   grant,
  output logic           active,
  output logic           start_err
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N - 1);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t           state, state_n;
  logic [PTR_W-1:0] rr_ptr, rr_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [N-1:0]     req_ack_n, grant_n;
  logic             tx_val_n, err_n;
  logic [7:0]       tx_data_n;
  logic             win_found;
  logic [PTR_W-1:0] win_idx;
  int unsigned      cand;

  // Search starts at rr_ptr so the most recently served channel goes to the back.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(rr_ptr) + k) % N;
      if (!win_found && req_val[cand]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(cand);
      end
    end
  end

  always_comb begin
    state_n   = state;
    rr_n      = rr_ptr;
    cnt_n     = cnt;
    req_ack_n = '0;
    grant_n   = grant;
    tx_val_n  = tx_val;
    tx_data_n = tx_data;
    err_n     = 1'b0;
    case (state)
      IDLE: begin
        if (win_found && !busy) begin
          req_ack_n = N'(1) << win_idx;
          grant_n   = N'(1) << win_idx;
          tx_data_n = req_data[{win_idx, 3'b000} +: 8];
          tx_val_n  = 1'b1;
          cnt_n     = '0;
          rr_n      = (win_idx == PTR_LAST) ? '0 : win_idx + PTR_W'(1);
          state_n   = WAIT_BUSY;
        end
      end
      // A busy that rises on the expiry edge still counts as a successful start.
      WAIT_BUSY: begin
        if (busy) begin
          tx_val_n = 1'b0;
          state_n  = WAIT_DONE;
        end else if (cnt == CNT_LAST) begin
          tx_val_n = 1'b0;
          grant_n  = '0;
          err_n    = 1'b1;
          state_n  = IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        tx_val_n = 1'b0;
        if (!busy) begin
          grant_n = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cnt       <= '0;
      req_ack   <= '0;
      grant     <= '0;
      tx_val    <= 1'b0;
      tx_data   <= 8'h00;
      start_err <= 1'b0;
    end else begin
      state     <= state_n;
      rr_ptr    <= rr_n;
      cnt       <= cnt_n;
      req_ack   <= req_ack_n;
      grant     <= grant_n;
      tx_val    <= tx_val_n;
      tx_data   <= tx_data_n;
      start_err <= err_n;
    end
  end

  assign active = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural UART_Tx busy model and
// simple requesters that drop their request once acknowledged unless held.
module tb_uart_tx_arbiter;

  localparam int N     = 4;
  localparam int TMO   = 8;
  localparam int RISE  = 3;
  localparam int FRAME = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_val;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ack;
  logic           busy;
  logic           tx_val;
  logic [7:0]     tx_data;
  logic [N-1:0]   grant;
  logic           active;
  logic           start_err;

  uart_tx_arbiter #(.N(N), .START_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req_val(req_val), .req_data(req_data), .req_ack(req_ack),
    .busy(busy), .tx_val(tx_val), .tx_data(tx_data), .grant(grant),
    .active(active), .start_err(start_err)
  );

  always #5 clk = ~clk;

  int checks;
  int failures;
  int cycle;
  int dly;
  int len;
  int fall_cyc;
  int err_seen;
  logic [N-1:0] hold_mask;
  logic busy_m;
  logic busy_ext;
  logic model_en;
  logic tx_val_prev;
  logic [7:0]   frame_log[$];
  logic [N-1:0] ack_log[$];
  int           gap_log[$];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] v, input logic [8*N-1:0] d);
    req_val  = v;
    req_data = d;
  endtask

  // One cycle: advance to the falling edge, then update requesters and the busy model.
  task automatic tick();
    @(negedge clk);
    cycle++;
    if (req_ack != '0) ack_log.push_back(req_ack);
    for (int i = 0; i < N; i++)
      if (req_ack[i] && !hold_mask[i]) req_val[i] = 1'b0;
    if (start_err) err_seen++;
    if (model_en && !rst) begin
      if (!busy_m) begin
        if (tx_val) begin
          dly++;
          if (dly == RISE) begin
            busy_m = 1'b1;
            dly    = 0;
            len    = 0;
            frame_log.push_back(tx_data);
          end
        end else begin
          dly = 0;
        end
      end else begin
        len++;
        if (len == FRAME) begin
          busy_m   = 1'b0;
          fall_cyc = cycle;
        end
      end
    end
    if (tx_val && !tx_val_prev && fall_cyc >= 0) begin
      gap_log.push_back(cycle - fall_cyc);
      fall_cyc = -1;
    end
    tx_val_prev = tx_val;
    busy = busy_m | busy_ext;
  endtask

  task automatic doReset();
    rst       = 1'b1;
    req_val   = '0;
    hold_mask = '0;
    busy_m    = 1'b0;
    busy_ext  = 1'b0;
    model_en  = 1'b1;
    busy      = 1'b0;
    dly       = 0;
    len       = 0;
    tick();
    tick();
    rst = 1'b0;
    frame_log.delete();
    ack_log.delete();
    gap_log.delete();
    fall_cyc    = -1;
    err_seen    = 0;
    tx_val_prev = 1'b0;
  endtask

  task automatic waitFrames(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && frame_log.size() < n; i++) tick();
    checkOutput(tag, frame_log.size(), n);
  endtask

  function automatic logic [31:0] frameAt(input int k);
    return (k < frame_log.size()) ? 32'(frame_log[k]) : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] ackAt(input int k);
    return (k < ack_log.size()) ? 32'(ack_log[k]) : 32'hFFFF_FFFF;
  endfunction

  initial begin
    int n_tx;
    int n_err;
    int n_ack;
    logic [N-1:0] err_grant;
    logic err_active;
    logic [7:0] exp2 [5];
    logic [N-1:0] ack2 [5];

    checks   = 0;
    failures = 0;
    cycle    = 0;
    req_data = '0;
    doReset();

    checkOutput("rst_tx_val", tx_val, 0);
    checkOutput("rst_tx_data", tx_data, 0);
    checkOutput("rst_grant", grant, 0);
    checkOutput("rst_req_ack", req_ack, 0);
    checkOutput("rst_active", active, 0);
    checkOutput("rst_start_err", start_err, 0);

    // Single request on ch2, cycle-accurate walk through one frame.
    applyStimulus(4'b0100, 32'h00AC_0000);
    tick();
    checkOutput("t1_ack", req_ack, 4'b0100);
    checkOutput("t1_tx_val", tx_val, 1);
    checkOutput("t1_tx_data", tx_data, 8'hAC);
    checkOutput("t1_grant", grant, 4'b0100);
    checkOutput("t1_active", active, 1);
    tick();
    checkOutput("t1_ack_once", req_ack, 0);
    checkOutput("t1_tx_val_hold", tx_val, 1);
    tick();
    checkOutput("t1_tx_val_busy_edge", tx_val, 1);
    tick();
    checkOutput("t1_tx_val_drop", tx_val, 0);
    checkOutput("t1_grant_done", grant, 4'b0100);
    tick(); tick(); tick();
    checkOutput("t1_grant_before_fall", grant, 4'b0100);
    tick();
    checkOutput("t1_grant_clear", grant, 0);
    checkOutput("t1_active_clear", active, 0);
    checkOutput("t1_frame", frameAt(0), 8'hAC);

    // All four channels held: strict rotation and a single idle cycle between frames.
    doReset();
    hold_mask = 4'b1111;
    applyStimulus(4'b1111, 32'h4433_2211);
    waitFrames("t2_frames", 5, 120);
    req_val = '0;
    exp2 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    ack2 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("t2_frame%0d", k), frameAt(k), 32'(exp2[k]));
      checkOutput($sformatf("t2_ack%0d", k), ackAt(k), 32'(ack2[k]));
    end
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("t2_gap%0d", k), (k < gap_log.size()) ? gap_log[k] : -1, 2);

    // ch0 and ch3 compete; ch1/ch2 carry data but never request.
    doReset();
    hold_mask = 4'b1001;
    applyStimulus(4'b1001, 32'hA3B2_B1A0);
    waitFrames("t3_frames", 4, 100);
    req_val = '0;
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("t3_frame%0d", k), frameAt(k), (k % 2 == 0) ? 32'hA0 : 32'hA3);
      checkOutput($sformatf("t3_ack%0d", k), ackAt(k), (k % 2 == 0) ? 32'h1 : 32'h8);
    end

    // Start timeout: busy never rises.
    doReset();
    model_en = 1'b0;
    applyStimulus(4'b0010, 32'h0000_7700);
    n_tx = 0; n_err = 0; n_ack = 0;
    err_grant = '1; err_active = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx_val) n_tx++;
      if (req_ack[1]) n_ack++;
      if (start_err) begin
        n_err++;
        err_grant  = grant;
        err_active = active;
      end
    end
    checkOutput("t4_tx_val_cycles", n_tx, TMO);
    checkOutput("t4_start_err_pulses", n_err, 1);
    checkOutput("t4_grant_after", err_grant, 0);
    checkOutput("t4_active_after", err_active, 0);
    checkOutput("t4_ack_count", n_ack, 1);

    // External busy blocks grants; reset during WAIT_DONE; rr_ptr restarts at ch0.
    doReset();
    busy_ext = 1'b1;
    busy     = 1'b1;
    applyStimulus(4'b0001, 32'h0000_005A);
    n_ack = 0; n_tx = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (req_ack != '0) n_ack++;
      if (active) n_tx++;
    end
    checkOutput("t5_blocked_acks", n_ack, 0);
    checkOutput("t5_blocked_active", n_tx, 0);
    busy_ext = 1'b0;
    busy     = busy_m;
    for (int i = 0; i < 5 && req_ack == '0; i++) tick();
    checkOutput("t5_unblocked_ack", req_ack, 4'b0001);
    for (int i = 0; i < 10 && !busy_m; i++) tick();
    tick(); tick();
    checkOutput("t5_wait_done_tx_val", tx_val, 0);
    checkOutput("t5_wait_done_active", active, 1);
    rst    = 1'b1;
    busy_m = 1'b0;
    busy   = 1'b0;
    dly    = 0;
    applyStimulus(4'b1111, 32'h4433_225A);
    tick();
    checkOutput("t5_rst_tx_val", tx_val, 0);
    checkOutput("t5_rst_grant", grant, 0);
    checkOutput("t5_rst_tx_data", tx_data, 0);
    checkOutput("t5_rst_active", active, 0);
    checkOutput("t5_rst_ack", req_ack, 0);
    rst = 1'b0;
    tick();
    checkOutput("t5_post_rst_ack", req_ack, 4'b0001);
    checkOutput("t5_post_rst_data", tx_data, 8'h5A);

    // Two back-to-back bytes from different channels reach the transmitter in order.
    doReset();
    applyStimulus(4'b0100, 32'h00AC_0000);
    waitFrames("t6_first", 1, 40);
    applyStimulus(4'b0001, 32'h0000_005A);
    waitFrames("t6_second", 2, 60);
    checkOutput("t6_frame0", frameAt(0), 8'hAC);
    checkOutput("t6_frame1", frameAt(1), 8'h5A);
    checkOutput("t6_no_start_err", err_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
